// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one single-port SDRAM controller among NUM_PORTS requesters.
// Latency: grant 1 cycle after req seen in ARB, enable until busy, ack 1 cycle after read data / write end.
// Backpressure: requesters hold req until their one-cycle ack; one access outstanding at a time.
module sdram_arbiter #(
    parameter int NUM_PORTS   = 3,
    parameter int HADDR_WIDTH = 24,
    parameter int PTR_WIDTH   = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             req,
    input  logic [NUM_PORTS-1:0]             req_we,
    input  logic [NUM_PORTS*HADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*16-1:0]          req_wdata,
    output logic [NUM_PORTS-1:0]             ack,
    output logic [15:0]                      rdata,
    output logic [PTR_WIDTH-1:0]             grant_id,
    output logic [HADDR_WIDTH-1:0]           mem_rd_addr,
    output logic [HADDR_WIDTH-1:0]           mem_wr_addr,
    output logic [15:0]                      mem_wr_data,
    output logic                             mem_rd_enable,
    output logic                             mem_wr_enable,
    input  logic [15:0]                      mem_rd_data,
    input  logic                             mem_rd_ready,
    input  logic                             mem_busy
);

    typedef enum logic [1:0] {ARB, ISSUE, RUN, DONE} state_t;

    state_t                  state;
    logic [PTR_WIDTH-1:0]    last_ptr;
    logic                    we_r;
    logic [HADDR_WIDTH-1:0]  addr_r;
    logic [15:0]             wdata_r;

    logic [NUM_PORTS-1:0]    hi_mask;
    logic [NUM_PORTS-1:0]    masked;
    logic [NUM_PORTS-1:0]    cand;
    logic                    pick_vld;
    logic [PTR_WIDTH-1:0]    pick_idx;
    logic                    we_sel;
    logic [HADDR_WIDTH-1:0]  addr_sel;
    logic [15:0]             wdata_sel;

    // Ports strictly above the last winner get first look; otherwise wrap to the lowest requester.
    always_comb begin
        hi_mask  = ~((NUM_PORTS'(2) << last_ptr) - NUM_PORTS'(1));
        masked   = req & hi_mask;
        cand     = (|masked) ? masked : req;
        pick_vld = |cand;
        pick_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (|(cand & (NUM_PORTS'(1) << i)))
                pick_idx = PTR_WIDTH'(i);
        end
        we_sel    = |(req_we & (NUM_PORTS'(1) << pick_idx));
        addr_sel  = HADDR_WIDTH'(req_addr >> (int'(pick_idx) * HADDR_WIDTH));
        wdata_sel = 16'(req_wdata >> (int'(pick_idx) * 16));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ARB;
            ack      <= '0;
            rdata    <= '0;
            grant_id <= '0;
            last_ptr <= PTR_WIDTH'(NUM_PORTS - 1);
            we_r     <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
        end else begin
            ack <= '0;
            case (state)
                ARB: begin
                    if (pick_vld) begin
                        grant_id <= pick_idx;
                        last_ptr <= pick_idx;
                        we_r     <= we_sel;
                        addr_r   <= addr_sel;
                        wdata_r  <= wdata_sel;
                        state    <= ISSUE;
                    end
                end
                // Busy stays low while the controller refreshes, so the enable is simply held.
                ISSUE: begin
                    if (mem_busy)
                        state <= RUN;
                end
                RUN: begin
                    if (we_r ? !mem_busy : mem_rd_ready) begin
                        if (!we_r)
                            rdata <= mem_rd_data;
                        ack   <= NUM_PORTS'(1) << grant_id;
                        state <= DONE;
                    end
                end
                DONE: state <= ARB;
                default: state <= ARB;
            endcase
        end
    end

    assign mem_rd_enable = (state == ISSUE) && !we_r;
    assign mem_wr_enable = (state == ISSUE) && we_r;
    assign mem_rd_addr   = addr_r;
    assign mem_wr_addr   = addr_r;
    assign mem_wr_data   = wdata_r;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: behavioural SDRAM controller with refresh, per-port scoreboard and directed + random steps.
module tb_sdram_arbiter;
    localparam int N  = 3;
    localparam int HW = 24;
    localparam int REF_LEN = 6;

    logic              clk, rst_n;
    logic [N-1:0]      req, req_we, ack;
    logic [N*HW-1:0]   req_addr;
    logic [N*16-1:0]   req_wdata;
    logic [15:0]       rdata, mem_wr_data, mem_rd_data;
    logic [1:0]        grant_id;
    logic [HW-1:0]     mem_rd_addr, mem_wr_addr;
    logic              mem_rd_enable, mem_wr_enable, mem_rd_ready, mem_busy;

    sdram_arbiter #(.NUM_PORTS(N), .HADDR_WIDTH(HW), .PTR_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .grant_id(grant_id),
        .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_enable(mem_rd_enable), .mem_wr_enable(mem_wr_enable),
        .mem_rd_data(mem_rd_data), .mem_rd_ready(mem_rd_ready), .mem_busy(mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural SDRAM controller ----------------
    typedef enum logic [1:0] {C_IDLE, C_REF, C_BUSY} cst_t;
    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [15:0] wdata;
    } cmd_t;

    cst_t        c_state;
    int          c_lat;
    int          ref_cnt;
    int          ref_period = 300;
    int          lat_lo = 1;
    int          lat_hi = 4;
    bit          ref_kick = 1'b0;
    logic        c_we;
    logic [23:0] c_addr;
    int          accept_cnt = 0;
    cmd_t        cmd_q[$];
    logic [15:0] ctl_mem [logic [23:0]];
    logic [15:0] ref_mem [logic [23:0]];

    function automatic logic [15:0] dflt(input logic [23:0] a);
        return a[15:0] ^ 16'h3C5A;
    endfunction

    function automatic logic [15:0] ctl_rd(input logic [23:0] a);
        return ctl_mem.exists(a) ? ctl_mem[a] : dflt(a);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [23:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            c_state      <= C_IDLE;
            mem_busy     <= 1'b0;
            mem_rd_ready <= 1'b0;
            mem_rd_data  <= '0;
            ref_cnt      <= ref_period;
            c_lat        <= 0;
            cmd_q.delete();
        end else begin
            mem_rd_ready <= 1'b0;
            if (ref_cnt > 0) ref_cnt <= ref_cnt - 1;
            case (c_state)
                C_IDLE: begin
                    if (ref_cnt == 0 || ref_kick) begin
                        c_state <= C_REF;
                        c_lat   <= REF_LEN;
                    end else if (mem_rd_enable || mem_wr_enable) begin
                        accept_cnt <= accept_cnt + 1;
                        c_we   <= mem_wr_enable;
                        c_addr <= mem_wr_enable ? mem_wr_addr : mem_rd_addr;
                        cmd_q.push_back('{mem_wr_enable, mem_wr_enable ? mem_wr_addr : mem_rd_addr, mem_wr_data});
                        if (mem_wr_enable) ctl_mem[mem_wr_addr] = mem_wr_data;
                        c_lat    <= int'($urandom_range(lat_hi, lat_lo));
                        mem_busy <= 1'b1;
                        c_state  <= C_BUSY;
                    end
                end
                C_REF: begin
                    if (c_lat <= 1) begin
                        c_state <= C_IDLE;
                        ref_cnt <= ref_period;
                    end else c_lat <= c_lat - 1;
                end
                default: begin
                    if (c_lat == 0) begin
                        mem_busy <= 1'b0;
                        c_state  <= C_IDLE;
                        if (!c_we) begin
                            mem_rd_ready <= 1'b1;
                            mem_rd_data  <= ctl_rd(c_addr);
                        end
                    end else c_lat <= c_lat - 1;
                end
            endcase
        end
    end

    // ---------------- requester model / scoreboard ----------------
    logic [N-1:0] pend = '0;
    logic [N-1:0] got  = '0;
    logic         p_we    [N];
    logic [23:0]  p_addr  [N];
    logic [15:0]  p_wdata [N];
    int           waited  [N];
    int           rearm   [N];
    int           ack_cnt [N];
    int           ack_log[$];
    bit           rnd_mode = 1'b0;
    bit           prev_busy = 1'b0;
    int           ref_en_cycles = 0;
    int           seq_addr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_req(input int p, input logic we, input logic [23:0] a, input logic [15:0] d);
        pend[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_wdata[p] = d; waited[p] = 0;
        req[p] = 1'b1; req_we[p] = we;
        req_addr[p*HW +: HW] = a;
        req_wdata[p*16 +: 16] = d;
    endtask

    task automatic new_rand(input int p);
        new_req(p, 1'($urandom_range(1, 0)), 24'h000200 + 24'($urandom_range(7, 0)), 16'($urandom));
    endtask

    task automatic step();
        int   p;
        cmd_t c;
        @(negedge clk);
        got = '0;
        chk("en_exclusive", 32'(mem_rd_enable & mem_wr_enable), 32'h0);
        chk("ack_onehot0", 32'($onehot0(ack)), 32'h1);
        if (prev_busy && mem_busy)
            chk("en_low_in_run", 32'({mem_rd_enable, mem_wr_enable}), 32'h0);
        prev_busy = mem_busy;
        if (c_state == C_REF && (mem_rd_enable || mem_wr_enable)) ref_en_cycles++;
        if (ack !== '0 && $onehot(ack)) begin
            p = 0;
            for (int i = 0; i < N; i++) if (ack[i]) p = i;
            got[p] = 1'b1;
            ack_cnt[p]++;
            ack_log.push_back(p);
            chk("ack_port_pending", 32'(pend[p]), 32'h1);
            if (pend[p]) begin
                if (cmd_q.size() == 0) chk("cmd_issued", 32'h0, 32'h1);
                else begin
                    c = cmd_q.pop_front();
                    chk("cmd_we", 32'(c.we), 32'(p_we[p]));
                    chk("cmd_addr", 32'(c.addr), 32'(p_addr[p]));
                    if (p_we[p]) begin
                        chk("cmd_wdata", 32'(c.wdata), 32'(p_wdata[p]));
                        ref_mem[p_addr[p]] = p_wdata[p];
                    end else
                        chk("rdata", 32'(rdata), 32'(ref_rd(p_addr[p])));
                end
                for (int q = 0; q < N; q++) begin
                    if (q != p && pend[q]) begin
                        waited[q]++;
                        chk("fair_wait", 32'(waited[q] <= N - 1), 32'h1);
                    end
                end
            end
            pend[p] = 1'b0;
            if (rearm[p] > 0) begin
                rearm[p]--;
                seq_addr++;
                new_req(p, 1'b0, 24'h400000 + 24'(p * 256 + seq_addr), 16'h0);
            end else if (rnd_mode && $urandom_range(1, 0) == 1) new_rand(p);
            else req[p] = 1'b0;
        end
        if (rnd_mode)
            for (int q = 0; q < N; q++)
                if (!pend[q] && !got[q] && $urandom_range(3, 0) == 0) new_rand(q);
    endtask

    task automatic wait_ack(input int p, input int lim, input string tag);
        int n = 0;
        do begin step(); n++; end while (!got[p] && n < lim);
        chk({tag, "_ack_seen"}, 32'(got[p]), 32'h1);
    endtask

    task automatic wait_busy(input int lim, input string tag);
        int n = 0;
        do begin step(); n++; end while (mem_busy !== 1'b1 && n < lim);
        chk({tag, "_busy_seen"}, 32'(mem_busy), 32'h1);
    endtask

    initial begin
        int a0, a1, a2, start, n;
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0; rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin waited[i] = 0; rearm[i] = 0; ack_cnt[i] = 0; end

        // reset state
        repeat (3) step();
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_grant", 32'(grant_id), 32'h0);
        chk("rst_en", 32'({mem_rd_enable, mem_wr_enable}), 32'h0);
        chk("rst_addr", 32'(mem_rd_addr), 32'h0);
        chk("rst_wdata", 32'(mem_wr_data), 32'h0);
        rst_n = 1'b1;
        step();

        // single read on port 1
        ctl_mem[24'h012345] = 16'hBEEF;
        ref_mem[24'h012345] = 16'hBEEF;
        new_req(1, 1'b0, 24'h012345, 16'h0);
        wait_busy(20, "t1");
        chk("t1_en_at_busy", 32'(mem_rd_enable), 32'h1);
        step();
        chk("t1_en_dropped", 32'(mem_rd_enable), 32'h0);
        wait_ack(1, 40, "t1");
        chk("t1_ack", 32'(ack), 32'h2);
        chk("t1_rdata", 32'(rdata), 32'hBEEF);
        step();
        chk("t1_ack_one_cycle", 32'(ack), 32'h0);

        // write on port 0 then read back on port 2
        new_req(0, 1'b1, 24'h000100, 16'hA5A5);
        wait_ack(0, 40, "t2w");
        chk("t2w_ack", 32'(ack), 32'h1);
        new_req(2, 1'b0, 24'h000100, 16'h0);
        wait_ack(2, 40, "t2r");
        chk("t2r_ack", 32'(ack), 32'h4);
        chk("t2r_rdata", 32'(rdata), 32'hA5A5);

        // all three ports requesting continuously
        start = ack_log.size();
        for (int i = 0; i < N; i++) rearm[i] = 2;
        for (int i = 0; i < N; i++) new_req(i, 1'b0, 24'h400000 + 24'(i * 256), 16'h0);
        n = 0;
        while (ack_log.size() - start < 9 && n < 200) begin step(); n++; end
        chk("t3_count", 32'(ack_log.size() - start), 32'd9);
        if (ack_log.size() - start >= 9)
            for (int i = 0; i < 9; i++) chk("t3_order", 32'(ack_log[start + i]), 32'(i % N));
        repeat (3) step();

        // request colliding with a refresh
        a0 = accept_cnt;
        ref_en_cycles = 0;
        ref_kick = 1'b1;
        new_req(1, 1'b0, 24'h000777, 16'h0);
        step();
        ref_kick = 1'b0;
        wait_ack(1, 40, "t4");
        chk("t4_rdata", 32'(rdata), 32'(dflt(24'h000777)));
        chk("t4_en_held_in_ref", 32'(ref_en_cycles > 0), 32'h1);
        chk("t4_one_bact", 32'(accept_cnt - a0), 32'h1);
        step();

        // reset in the middle of a read
        lat_lo = 8; lat_hi = 8;
        new_req(2, 1'b0, 24'h000100, 16'h0);
        wait_busy(20, "t5");
        step();
        rst_n = 1'b0;
        step();
        chk("t5_no_ack", 32'(ack), 32'h0);
        chk("t5_en_off", 32'({mem_rd_enable, mem_wr_enable}), 32'h0);
        chk("t5_grant0", 32'(grant_id), 32'h0);
        rst_n = 1'b1;
        pend[2] = 1'b0; req[2] = 1'b0;
        lat_lo = 1; lat_hi = 4;
        new_req(0, 1'b0, 24'h000100, 16'h0);
        wait_ack(0, 40, "t5");
        chk("t5_ack", 32'(ack), 32'h1);
        chk("t5_rdata", 32'(rdata), 32'hA5A5);
        step();

        // dropped requests: after grant still served, before grant never served
        a1 = ack_cnt[1]; a2 = ack_cnt[2];
        new_req(1, 1'b0, 24'h000205, 16'h0);
        n = 0;
        do begin step(); n++; end while (mem_rd_enable !== 1'b1 && n < 20);
        chk("t6_granted", 32'(mem_rd_enable), 32'h1);
        req[1] = 1'b0; req_we[1] = 1'b1;
        req_addr[HW +: HW] = 24'hFFFFFF;
        req[2] = 1'b1;
        step();
        req[2] = 1'b0;
        wait_ack(1, 40, "t6");
        repeat (6) step();
        chk("t6_ack1_once", 32'(ack_cnt[1] - a1), 32'h1);
        chk("t6_no_ack2", 32'(ack_cnt[2] - a2), 32'h0);
        req_we[1] = 1'b0;

        // random traffic with frequent refresh
        ref_period = 60;
        rnd_mode = 1'b1;
        repeat (600) step();
        rnd_mode = 1'b0;
        n = 0;
        while (pend != '0 && n < 300) begin step(); n++; end
        chk("drain_pending", 32'(pend), 32'h0);
        req = '0;
        repeat (5) step();
        chk("cmd_queue_empty", 32'(cmd_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
